// File: rtl/fnd_pkg.sv
// fnd_pkg: shared 7-segment constants and the hex glyph table (gfedcba, active-high)
package fnd_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// fnd_scan_ctrl_if: application-side load bus plus the FND_COM/FND_DATA pin bundle
interface fnd_scan_ctrl_if #(parameter int N_DIGITS = 4);
  logic LOAD;
  logic [4*N_DIGITS-1:0] DIGITS;
  logic [N_DIGITS-1:0] DP;
  logic [N_DIGITS-1:0] BLANK;
  logic [N_DIGITS-1:0] BLINK;
  logic [3:0] BRIGHT;
  logic [N_DIGITS-1:0] FND_COM;
  logic [7:0] FND_DATA;
  logic FRAME_SYNC;
  modport master (
    output LOAD, DIGITS, DP, BLANK, BLINK, BRIGHT,
    input FND_COM, FND_DATA, FRAME_SYNC
  );
  modport slave (
    input LOAD, DIGITS, DP, BLANK, BLINK, BRIGHT,
    output FND_COM, FND_DATA, FRAME_SYNC
  );
endinterface

// File: rtl/fnd_hex_decode.sv
// fnd_hex_decode: combinational nibble to 7-segment pattern (gfedcba, active-high)
module fnd_hex_decode
  import fnd_pkg::*;
(
  input logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: N-digit multiplexed FND scanner with double-buffered load, blank/blink/dp and anti-ghost slot.
// Define FND_BRIGHT_EN to add 16-step brightness PWM within each dwell.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DWELL_CYC = 6000,
  parameter int BLINK_FRAMES = 250,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input logic CLK,
  input logic RESET,
  fnd_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(DWELL_CYC);
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef struct packed {
    logic [4*N_DIGITS-1:0] dig;
    logic [N_DIGITS-1:0] dp;
    logic [N_DIGITS-1:0] blank;
    logic [N_DIGITS-1:0] blink;
  } disp_t;
  localparam disp_t DISP_RST = '{dig: '0, dp: '0, blank: '1, blink: '0};
  localparam logic [N_DIGITS-1:0] COM_OFF = COM_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0] DATA_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] bcnt;
  logic ph, pend, wrap, bnd, bend, ghost, dark, duty_ok;
  disp_t sh, act, ld;
  logic [6:0] hseg;
  logic [N_DIGITS-1:0] com_n, com_q;
  logic [7:0] seg_n, data_q;
  logic fs_q;
  fnd_hex_decode u_dec (.nib(act.dig[4*idx +: 4]), .seg(hseg));
`ifdef FND_BRIGHT_EN
  logic [3:0] bright;
  always_ff @(posedge CLK) begin
    if (!RESET) bright <= 4'hF;
    else if (bnd) bright <= bus.BRIGHT;
  end
  assign duty_ok = int'(cnt) / (DWELL_CYC / 16) <= int'(bright);
`else
  logic unused_bright;
  assign unused_bright = ^bus.BRIGHT;
  assign duty_ok = 1'b1;
`endif
  always_comb begin
    wrap = cnt == CW'(DWELL_CYC - 1);
    bnd = wrap && idx == IW'(N_DIGITS - 1);
    bend = bcnt == BW'(BLINK_FRAMES - 1);
    ghost = cnt == '0;
    dark = act.blank[idx] | (act.blink[idx] & ~ph);
    com_n = ghost ? '0 : N_DIGITS'(1) << idx;
    seg_n = (ghost || dark || !duty_ok) ? SEG_OFF : {act.dp[idx], hseg};
    ld = '{dig: bus.DIGITS, dp: bus.DP, blank: bus.BLANK, blink: bus.BLINK};
  end
  // shadow->active happens only on the frame boundary so a frame never mixes two loads
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt <= '0;
      idx <= '0;
      bcnt <= '0;
      ph <= 1'b1;
      pend <= 1'b0;
      sh <= DISP_RST;
      act <= DISP_RST;
      com_q <= COM_OFF;
      data_q <= DATA_OFF;
      fs_q <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx == IW'(N_DIGITS - 1) ? '0 : idx + 1'b1;
      if (bus.LOAD) sh <= ld;
      if (bnd && pend) act <= sh;
      pend <= bus.LOAD || (pend && !bnd);
      if (bnd) bcnt <= bend ? '0 : bcnt + 1'b1;
      if (bnd && bend) ph <= ~ph;
      com_q <= COM_ACTIVE_LOW ? ~com_n : com_n;
      data_q <= SEG_ACTIVE_LOW ? ~seg_n : seg_n;
      fs_q <= ghost && idx == '0;
    end
  end
  assign bus.FND_COM = com_q;
  assign bus.FND_DATA = data_q;
  assign bus.FRAME_SYNC = fs_q;
endmodule
